// File: rtl/ecc_rd_err_mon_64_57.sv
// ============================================================================
// Module   : ecc_rd_err_mon_64_57
// Brief    : Registered consumer stage behind the 64/57 inverted-SECDED
//            decoder. It forwards corrected data, keeps saturating error
//            counters and a sticky fatal alarm, and optionally holds a
//            first-error log.
// Options  : ECC_RD_ERR_LOG_EN - builds the first-error log registers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_rd_err_mon_64_57 #(
    parameter int AddrWidth = 10,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [56:0]          dec_data_i,
    input  logic [6:0]           dec_syndrome_i,
    input  logic [1:0]           dec_err_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [56:0]          out_data_o,
    output logic [1:0]           out_err_o,
    output logic [AddrWidth-1:0] out_addr_o,
    input  logic                 cnt_clr_i,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o,
    output logic                 fatal_o,
    input  logic                 fatal_clr_i,
    output logic                 log_valid_o,
    output logic [AddrWidth-1:0] log_addr_o,
    output logic [6:0]           log_syndrome_o,
    input  logic                 log_clr_i
);

    localparam logic [CntWidth-1:0] c_cnt_max = '1;
    localparam logic [CntWidth-1:0] c_cnt_one = {{(CntWidth-1){1'b0}}, 1'b1};

    logic                 r_out_valid;
    logic [56:0]          r_out_data;
    logic [1:0]           r_out_err;
    logic [AddrWidth-1:0] r_out_addr;
    logic [CntWidth-1:0]  r_corr_cnt;
    logic [CntWidth-1:0]  r_uncorr_cnt;
    logic                 r_fatal;

    logic                 w_accept;
    logic                 w_corr_evt;
    logic                 w_uncorr_evt;
    logic [CntWidth-1:0]  w_corr_base;
    logic [CntWidth-1:0]  w_uncorr_base;
    logic [CntWidth-1:0]  w_corr_nxt;
    logic [CntWidth-1:0]  w_uncorr_nxt;

    assign in_ready_o = ~r_out_valid | out_ready_i;
    assign w_accept   = in_valid_i & in_ready_o;

    // 2'b11 is illegal from the decoder; treat it as uncorrectable
    assign w_corr_evt   = w_accept & (dec_err_i == 2'b01);
    assign w_uncorr_evt = w_accept & dec_err_i[1];

    // The clear zeroes the base so a same-cycle event lands on 1
    always_comb begin
        w_corr_base   = cnt_clr_i ? '0 : r_corr_cnt;
        w_uncorr_base = cnt_clr_i ? '0 : r_uncorr_cnt;
        w_corr_nxt    = w_corr_base;
        w_uncorr_nxt  = w_uncorr_base;
        if (w_corr_evt && (w_corr_base != c_cnt_max)) begin
            w_corr_nxt = w_corr_base + c_cnt_one;
        end
        if (w_uncorr_evt && (w_uncorr_base != c_cnt_max)) begin
            w_uncorr_nxt = w_uncorr_base + c_cnt_one;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
            r_out_addr  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= dec_data_i;
            r_out_err   <= dec_err_i;
            r_out_addr  <= in_addr_i;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
            r_fatal      <= 1'b0;
        end else begin
            r_corr_cnt   <= w_corr_nxt;
            r_uncorr_cnt <= w_uncorr_nxt;
            if (w_uncorr_evt) begin
                r_fatal <= 1'b1;
            end else if (fatal_clr_i) begin
                r_fatal <= 1'b0;
            end
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;
    assign out_err_o    = r_out_err;
    assign out_addr_o   = r_out_addr;
    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;
    assign fatal_o      = r_fatal;

`ifdef ECC_RD_ERR_LOG_EN
    logic                 r_log_valid;
    logic [AddrWidth-1:0] r_log_addr;
    logic [6:0]           r_log_syndrome;
    logic                 w_log_capture;

    // A clear reopens the log in the same cycle for an arriving error
    assign w_log_capture = (w_corr_evt | w_uncorr_evt) & (~r_log_valid | log_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_log_valid    <= 1'b0;
            r_log_addr     <= '0;
            r_log_syndrome <= '0;
        end else if (w_log_capture) begin
            r_log_valid    <= 1'b1;
            r_log_addr     <= in_addr_i;
            r_log_syndrome <= dec_syndrome_i;
        end else if (log_clr_i) begin
            r_log_valid    <= 1'b0;
            r_log_addr     <= '0;
            r_log_syndrome <= '0;
        end
    end

    assign log_valid_o    = r_log_valid;
    assign log_addr_o     = r_log_addr;
    assign log_syndrome_o = r_log_syndrome;
`else
    logic w_unused_log_in;

    assign w_unused_log_in = log_clr_i ^ (^dec_syndrome_i);
    assign log_valid_o     = 1'b0;
    assign log_addr_o      = '0;
    assign log_syndrome_o  = '0;
`endif

endmodule

`default_nettype wire

// File: doc/ecc_rd_err_mon_64_57.md
Name: ecc_rd_err_mon_64_57

Overview:
Registered consumer stage placed directly after the 64/57 inverted-SECDED decoder on a memory read path. It accepts the decoded data, syndrome and error flags with a valid/ready handshake. It forwards corrected data through one pipeline register and maintains saturating correctable and uncorrectable error counters. It also raises a sticky fatal alarm on any uncorrectable error.

Parameters:
AddrWidth, 10, width of the read address carried alongside each word
CntWidth, 16, width of each error counter; counters saturate at 2**CntWidth-1

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  decoder output valid
in_ready_o  output  1  stage can accept a word
in_addr_i  input  AddrWidth  address of the word being decoded
dec_data_i  input  57  corrected data from the decoder
dec_syndrome_i  input  7  syndrome from the decoder
dec_err_i  input  2  decoder error flags: bit0 correctable, bit1 uncorrectable
out_valid_o  output  1  registered word valid
out_ready_i  input  1  downstream accepts the word
out_data_o  output  57  registered corrected data
out_err_o  output  2  registered error flags
out_addr_o  output  AddrWidth  registered address
cnt_clr_i  input  1  synchronous clear of both counters
corr_cnt_o  output  CntWidth  correctable error count
uncorr_cnt_o  output  CntWidth  uncorrectable error count
fatal_o  output  1  sticky: an uncorrectable error was accepted
fatal_clr_i  input  1  synchronous clear of fatal_o
log_valid_o  output  1  first-error log holds an entry
log_addr_o  output  AddrWidth  address of the first logged error
log_syndrome_o  output  7  syndrome of the first logged error
log_clr_i  input  1  clears the first-error log

Behaviour:
- Reset (rst_ni=0, asynchronous): every output register is 0. This covers out_valid_o, out_data_o, out_err_o, out_addr_o, both counters, fatal_o and all log_* outputs.
- Handshake: in_ready_o = ~out_valid_o | out_ready_i, purely combinational. A word is accepted when in_valid_i & in_ready_o.
- On accept, the word loads the output register in the next cycle and out_valid_o=1. Latency is 1 cycle.
- If out_valid_o & out_ready_i and no word is accepted in the same cycle, out_valid_o clears next cycle.
- Output payload holds stable while out_valid_o & ~out_ready_i.
- Simultaneous accept and output drain in one cycle gives back-to-back throughput of 1 word per cycle.
- Error classification is evaluated only on accepted words:
  - corr = dec_err_i==2'b01
  - uncorr = dec_err_i[1] (2'b10). The illegal value 2'b11 is also treated as uncorrectable.
  - No error for 2'b00.
- Counters:
  - Increment by 1 on each accepted corr or uncorr event.
  - Hold at all-ones once saturated; no wrap-around.
  - cnt_clr_i alone resets both counters to 0.
  - cnt_clr_i together with an event gives the affected counter 1 and the other counter 0.
- fatal_o sets on an accepted uncorr event. fatal_clr_i clears it, but a same-cycle set has priority, so fatal_o stays 1.
- Words with errors are still forwarded. out_err_o carries the flags; the block never drops data.
- Syndrome is used only by the log. It is not re-checked against dec_err_i.
- Reset asserted mid-transfer discards the registered word. No replay.

Optional Feature:
ECC_RD_ERR_LOG_EN
- Defined:
  - On the first accepted corr or uncorr event while log_valid_o=0, capture in_addr_i and dec_syndrome_i, and set log_valid_o.
  - Later errors are ignored until log_clr_i.
  - log_clr_i clears the log. If a same-cycle error arrives, it captures the new event and log_valid_o stays 1.
- Undefined: log_valid_o, log_addr_o and log_syndrome_o are tied to 0. log_clr_i is ignored. No log registers are built.

Test Plan:
- Reset then 4 clean words (dec_err_i=0, data 57'h1, 57'h2, 57'h3, 57'h4), out_ready_i=1 -> outputs appear 1 cycle later, back-to-back; counters 0; fatal_o=0.
- Backpressure: out_ready_i=0 with a word held -> in_ready_o=0; payload stable for 5 cycles; raising out_ready_i releases the word with no loss or duplicate.
- Saturation with CntWidth=4: 20 accepted words with dec_err_i=2'b01 -> corr_cnt_o=4'hF; uncorr_cnt_o=0.
- dec_err_i=2'b10 at addr 10'h3A, syndrome 7'h54 -> uncorr_cnt_o=1, fatal_o=1. fatal_clr_i clears it. fatal_clr_i together with a second uncorr event keeps fatal_o=1.
- cnt_clr_i in the same cycle as a correctable event -> corr_cnt_o=1, uncorr_cnt_o=0. dec_err_i=2'b11 counts as uncorrectable.
- With ECC_RD_ERR_LOG_EN: errors at addr 10'h005 then 10'h006 -> log_addr_o=10'h005 is retained. After log_clr_i, log_valid_o=0. Without the macro, log outputs stay 0.
